// File: rtl/vga_capture.sv
// VGA sink: locks to incoming sync timing, checks it against the configured mode and emits a pixel write stream.
// Defining VGA_CAPTURE_CRC_EN adds a per-frame CRC-16/CCITT output (frame_crc).
module vga_capture #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int CLK_PER_PIX = 4,
    parameter int SYNC_POL    = 0,
    parameter int ADDR_W      = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic [3:0]        red,
    input  logic [3:0]        green,
    input  logic [3:0]        blue,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [11:0]       pix_data,
    output logic              frame_start,
    output logic              frame_done,
    output logic              locked,
    output logic [2:0]        err,
    input  logic              err_clr,
    output logic [15:0]       frame_cnt
`ifdef VGA_CAPTURE_CRC_EN
    ,
    output logic [15:0]       frame_crc
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int PH_W    = $clog2(CLK_PER_PIX);
    localparam int HCNT_W  = $clog2(H_TOTAL + 1);
    localparam int VCNT_W  = $clog2(V_TOTAL + 1);
    localparam int HLEN_W  = $clog2(H_TOTAL * CLK_PER_PIX + 1);

    localparam logic              ACT_LVL   = (SYNC_POL != 0);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_PER_PIX - 1);
    localparam logic [PH_W-1:0]   PH_MID    = PH_W'(CLK_PER_PIX / 2);
    localparam logic [HCNT_W-1:0] H_LAST    = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_MAX     = HCNT_W'(H_TOTAL);
    localparam logic [HCNT_W-1:0] H_WIN_LO  = HCNT_W'(H_SYNC + H_BACK);
    localparam logic [HCNT_W-1:0] H_WIN_HI  = HCNT_W'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [VCNT_W-1:0] V_LAST    = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_MAX     = VCNT_W'(V_TOTAL);
    localparam logic [VCNT_W-1:0] V_WIN_LO  = VCNT_W'(V_SYNC + V_BACK);
    localparam logic [VCNT_W-1:0] V_WIN_HI  = VCNT_W'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [VCNT_W-1:0] VS_LINES  = VCNT_W'(V_SYNC);
    localparam logic [HLEN_W-1:0] HS_CLKS   = HLEN_W'(H_SYNC * CLK_PER_PIX);
    localparam logic [HLEN_W-1:0] HLEN_MAX  = HLEN_W'(H_TOTAL * CLK_PER_PIX);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_VISIBLE * V_VISIBLE - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_H_ALIGN  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                hs_r, hs_d_r, vs_r, vs_d_r, en_r;
    logic [11:0]         rgb_r, rgb_d_r;
    logic [PH_W-1:0]     ph_r;
    logic [HCNT_W-1:0]   hcnt_r;
    logic [VCNT_W-1:0]   vcnt_r, vlen_r;
    logic [HLEN_W-1:0]   hlen_r;
    logic [ADDR_W-1:0]   addr_cnt_r;
    logic                h_edge_s, h_fall_s, v_edge_s, v_fall_s, line_end_s, in_win_s;
    logic [2:0]          err_det_s;
    logic                err_any_s, frame_start_s, sample_s, locked_s, frame_done_s;

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc_acc_r;

    function automatic logic [15:0] crc16_px(input logic [15:0] crc, input logic [11:0] px);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 11; i >= 0; i--) begin
            fb = c[15] ^ px[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction
`endif

    // Input capture; syncs reset to their inactive level so release never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_r    <= ~ACT_LVL;
            hs_d_r  <= ~ACT_LVL;
            vs_r    <= ~ACT_LVL;
            vs_d_r  <= ~ACT_LVL;
            en_r    <= 1'b0;
            rgb_r   <= 12'h000;
            rgb_d_r <= 12'h000;
        end else begin
            hs_r    <= h_sync;
            hs_d_r  <= hs_r;
            vs_r    <= v_sync;
            vs_d_r  <= vs_r;
            en_r    <= en;
            rgb_r   <= {red, green, blue};
            rgb_d_r <= rgb_r;
        end
    end

    assign h_edge_s   = (hs_r == ACT_LVL) && (hs_d_r != ACT_LVL);
    assign h_fall_s   = (hs_r != ACT_LVL) && (hs_d_r == ACT_LVL);
    assign v_edge_s   = (vs_r == ACT_LVL) && (vs_d_r != ACT_LVL);
    assign v_fall_s   = (vs_r != ACT_LVL) && (vs_d_r == ACT_LVL);
    assign line_end_s = (hcnt_r == H_LAST) && (ph_r == PH_LAST);
    // Counters trail rgb_r by one clk (edge detect latency), hence sampling rgb_d_r.
    assign in_win_s   = (hcnt_r >= H_WIN_LO) && (hcnt_r < H_WIN_HI) &&
                        (vcnt_r >= V_WIN_LO) && (vcnt_r < V_WIN_HI);

    // Pixel phase, column and line counters; saturate at the total when edges go missing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph_r   <= '0;
            hcnt_r <= '0;
            vcnt_r <= '0;
        end else begin
            if (h_edge_s) begin
                ph_r   <= '0;
                hcnt_r <= '0;
            end else if (ph_r == PH_LAST) begin
                ph_r   <= '0;
                hcnt_r <= (hcnt_r != H_MAX) ? hcnt_r + HCNT_W'(1) : hcnt_r;
            end else begin
                ph_r   <= ph_r + PH_W'(1);
            end
            if (v_edge_s) begin
                vcnt_r <= '0;
            end else if (h_edge_s && (vcnt_r != V_MAX)) begin
                vcnt_r <= vcnt_r + VCNT_W'(1);
            end else begin
                vcnt_r <= vcnt_r;
            end
        end
    end

    // Sync pulse widths: h_sync in clks, v_sync in lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hlen_r <= '0;
            vlen_r <= '0;
        end else begin
            if (h_edge_s) begin
                hlen_r <= HLEN_W'(1);
            end else if ((hs_r == ACT_LVL) && (hlen_r != HLEN_MAX)) begin
                hlen_r <= hlen_r + HLEN_W'(1);
            end else begin
                hlen_r <= hlen_r;
            end
            if (v_edge_s) begin
                vlen_r <= VCNT_W'(1);
            end else if ((vs_r == ACT_LVL) && h_edge_s && (vlen_r != V_MAX)) begin
                vlen_r <= vlen_r + VCNT_W'(1);
            end else begin
                vlen_r <= vlen_r;
            end
        end
    end

    // Timing checks, only meaningful once locked.
    always_comb begin
        err_det_s = 3'b000;
        if (state_r == ST_LOCKED) begin
            err_det_s[0] = h_edge_s ? ~line_end_s : line_end_s;
            err_det_s[1] = (h_fall_s && (hlen_r != HS_CLKS)) || (v_fall_s && (vlen_r != VS_LINES));
            err_det_s[2] = v_edge_s ? (vcnt_r != V_LAST) : (h_edge_s && (vcnt_r == V_LAST));
        end else begin
            err_det_s = 3'b000;
        end
    end
    assign err_any_s = |err_det_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_UNLOCKED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_UNLOCKED: state_nxt_s = h_edge_s ? ST_H_ALIGN : ST_UNLOCKED;
            ST_H_ALIGN:  state_nxt_s = v_edge_s ? ST_LOCKED : ST_H_ALIGN;
            ST_LOCKED:   state_nxt_s = err_any_s ? ST_UNLOCKED : ST_LOCKED;
            default:     state_nxt_s = ST_UNLOCKED;
        endcase
        if (!en_r) begin
            state_nxt_s = ST_UNLOCKED;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // FSM outputs.
    always_comb begin
        frame_start_s = 1'b0;
        sample_s      = 1'b0;
        case (state_r)
            ST_H_ALIGN: frame_start_s = en_r && v_edge_s;
            ST_LOCKED: begin
                frame_start_s = en_r && v_edge_s && !err_any_s;
                sample_s      = en_r && !err_any_s && (ph_r == PH_MID) && in_win_s;
            end
            default: begin
                frame_start_s = 1'b0;
                sample_s      = 1'b0;
            end
        endcase
        locked_s     = (state_nxt_s == ST_LOCKED);
        frame_done_s = pix_valid && (pix_addr == ADDR_LAST) && (state_r == ST_LOCKED);
    end

    // Registered pixel stream, frame markers, sticky errors and frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid   <= 1'b0;
            pix_addr    <= '0;
            pix_data    <= 12'h000;
            addr_cnt_r  <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            locked      <= 1'b0;
            err         <= 3'b000;
            frame_cnt   <= 16'd0;
        end else begin
            pix_valid   <= sample_s;
            frame_start <= frame_start_s;
            frame_done  <= frame_done_s;
            locked      <= locked_s;
            err         <= (err_clr ? 3'b000 : err) | err_det_s;
            frame_cnt   <= frame_done_s ? frame_cnt + 16'd1 : frame_cnt;
            if (sample_s) begin
                pix_addr <= addr_cnt_r;
                pix_data <= rgb_d_r;
            end else begin
                pix_addr <= pix_addr;
                pix_data <= pix_data;
            end
            if (frame_start_s) begin
                addr_cnt_r <= '0;
            end else if (sample_s) begin
                addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
            end else begin
                addr_cnt_r <= addr_cnt_r;
            end
        end
    end

`ifdef VGA_CAPTURE_CRC_EN
    // Running frame CRC, published when the frame completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_acc_r <= 16'h0000;
            frame_crc <= 16'h0000;
        end else begin
            if (frame_start_s) begin
                crc_acc_r <= 16'h0000;
            end else if (sample_s) begin
                crc_acc_r <= crc16_px(crc_acc_r, rgb_d_r);
            end else begin
                crc_acc_r <= crc_acc_r;
            end
            frame_crc <= frame_done_s ? crc_acc_r : frame_crc;
        end
    end
`endif

endmodule
